mmio_uart_tx: RTL

Memory-mapped UART transmitter on the single-cycle RISC-V data bus. It sits directly downstream of the CPU store path in the lab505 top. It accepts byte writes from `sw` instructions into a FIFO and serialises them, 8N1 and LSB first, onto a `tx` pin. The CPU polls its status register with `lw` so that software can print to a host terminal.

---
 rtl/mmio_uart_tx.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA writes feed a FIFO, bytes go out 8N1 LSB-first on tx.
// Latency: store at edge N is popped at edge N+1, tx falls after edge N+2; rdata is combinational.
// Backpressure: none on the bus; a store to a full FIFO is dropped and sets sticky overflow.
// Optional even-parity framing (8E1) is built when UART_TX_PARITY_EN is defined.
module mmio_uart_tx #(
    parameter int CLKS_PER_BIT = 174,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        CLOCK_20,
    input  logic        RESET,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic       PAR_FLAG = 1'b1;
`else
    localparam logic       PAR_FLAG = 1'b0;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    logic          ov_q, ov_d;

    // Serialiser state
    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic wr_txdata, wr_status;
    logic full, empty, push, pop, baud_end;
    logic [7:0] head;
    logic [31:0] status;

    // Only the low byte of a store is transmitted; upper bits are don't-care.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    assign wr_txdata = sel & we & (addr == 4'h0);
    assign wr_status = sel & we & (addr == 4'h4);

    // Full/empty come from registered count, so a same-cycle pop never frees a slot for a push
    // and a freshly pushed byte is not visible to the FSM until the next cycle.
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign push     = wr_txdata & ~full;
    assign pop      = (state_q == S_IDLE) & ~empty;
    assign head     = mem_q[rd_ptr_q];
    assign baud_end = (baud_q == BAUD_LAST);

    // Occupancy and sticky overflow; a set in the same cycle as a clear wins.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
        ov_d = ov_q;
        if (wr_txdata && full) begin
            ov_d = 1'b1;
        end else if (wr_status && wdata[3]) begin
            ov_d = 1'b0;
        end
    end

    // FIFO pointer, count and overflow registers
    always_ff @(posedge CLOCK_20 or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ov_q    <= ov_d;
        end
    end

    // FIFO data array; contents need no reset since the pointers gate validity
    always_ff @(posedge CLOCK_20) begin
        if (push) mem_q[wr_ptr_q] <= wdata[7:0];
    end

    // Frame sequencer: IDLE pops, then START, 8 DATA bits, optional PARITY, STOP
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    shift_d = head;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                end
            end
            S_START: begin
                if (baud_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (baud_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level follows the current state; registering it delays tx one cycle behind the FSM
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // FSM and registered outputs; reset forces tx high immediately, aborting any frame
    always_ff @(posedge CLOCK_20 or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= (count_q != '0) || (state_q != S_IDLE);
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Load path: combinational so a single-cycle lw completes in its own cycle
    always_comb begin
        status       = '0;
        status[0]    = full;
        status[1]    = empty;
        status[2]    = (state_q != S_IDLE);
        status[3]    = ov_q;
        status[4]    = PAR_FLAG;
        status[11:8] = 4'(count_q);
        rdata        = '0;
        if (sel && (addr == 4'h4)) rdata = status;
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule
